nx_event_coalescer: RTL and testbench
=====================================

Name: nx_event_coalescer

Overview:
- Upstream feeder for the event counter array.
- Collects up to N_EVENTS independent event strobes per cycle, each with its own increment.
- Accumulates them in per-source pending registers and drains them, round-robin, into the single count_stb/count_by/count_id increment port the counter array accepts each cycle.
- No event is lost unless a pending register saturates.

Parameters:
- N_EVENTS, 4: number of event sources; must be >= 1.
- N_EVENT_BY_BITS, 1: width of each source's per-cycle increment.
- N_COUNT_BY_BITS, 8: width of each pending accumulator and of count_by; must be >= N_EVENT_BY_BITS.
- N_COUNTERS, 16: size of the downstream counter array; sets the count_id width to clog2(N_COUNTERS), minimum 1.
- ID_BASE, 0: counter index of source 0; source i maps to count_id = ID_BASE+i; ID_BASE+N_EVENTS <= N_COUNTERS.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- event_stb, input, N_EVENTS: bit i = source i has an event this cycle.
- event_by, input, N_EVENTS*N_EVENT_BY_BITS: packed increments; slice i belongs to source i; ignored when event_stb[i]=0.
- drain_en, input, 1: 1 = arbiter may issue increments; 0 = accumulate only.
- count_stb, output, 1: increment valid; connects to the counter array's count_stb.
- count_by, output, N_COUNT_BY_BITS: increment amount.
- count_id, output, clog2(N_COUNTERS): target counter.
- busy, output, 1: at least one pending accumulator is nonzero (registered).

Behaviour:
- Reset values: all pending accumulators 0; rr_ptr = 0; count_stb = 0; count_by = 0; count_id = 0; busy = 0.
- Reset is asynchronous and may occur mid-drain. Pending counts are discarded, and count_stb deasserts immediately on rst_n low.
- Accumulate, per source i, each edge:
  - pend_i_next = sat(pend_i_kept + (event_stb[i] ? event_by[i] : 0)).
  - pend_i_kept = 0 if i is granted this cycle, else pend_i.
  - Arithmetic is done at N_COUNT_BY_BITS+1 bits. If the carry is set, the result is all-ones (saturate).
- Grant: combinational on the current pend values.
  - Considered only when drain_en = 1.
  - Pick the first i with pend_i != 0, scanning from rr_ptr upward and wrapping at N_EVENTS-1 -> 0.
  - On a grant, rr_ptr <= granted index + 1 (mod N_EVENTS). With no grant, rr_ptr holds.
- Output register, each edge:
  - count_stb <= grant_valid.
  - On a grant: count_by <= pend_granted, count_id <= ID_BASE + granted index.
  - Without a grant: count_by and count_id hold their last values.
  - count_stb is high for exactly one cycle per issued increment.
- Latency: an event sampled at edge k is in pend after edge k, and count_stb can be high after edge k+1 at the earliest. That is two edges from event to increment.
- Simultaneous grant and new event on the same source: the granted value is issued and the new event becomes the new pending value. Nothing is double-counted or dropped.
- One increment per cycle maximum. A source is re-granted only after every other nonzero source has been served (fairness).
- drain_en = 0: accumulators keep collecting (and saturate if needed); count_stb = 0 from the next edge.
- busy <= OR of pend_i_next across all sources.
- Back-pressure: none. The counter array always accepts an increment.

Optional Feature:
- Macro: NX_EVENT_COALESCER_OVFL_EN.
- Defined:
  - Adds output ovfl_sticky (N_EVENTS bits) and input ovfl_clr (N_EVENTS bits).
  - ovfl_sticky[i] sets on any edge where source i's accumulate saturated (carry set).
  - ovfl_sticky[i] clears on ovfl_clr[i]; a set and a clear in the same cycle leave it set.
  - Reset value is 0.
- Not defined: those ports do not exist, and saturation is silent.

Test Plan:
- Single event: N_EVENTS=4, ID_BASE=8, drain_en=1, event_stb=0001 with by=1 for one cycle -> two edges later count_stb high for 1 cycle with count_by=1, count_id=8; busy high for 1 cycle.
- All sources at once: event_stb=1111 for one cycle, each by=1 -> count_stb high 4 consecutive cycles with count_id 8, 9, 10, 11 and count_by=1 each; then idle.
- Continuous source 2 with others sparse: event_stb[2]=1 every cycle, event_stb[0] pulsed once -> source 0 is granted within N_EVENTS cycles. The summed count_by for id 10 equals the number of cycles source 2 was strobed.
- Grant plus same-cycle event: pend_1=5 is granted while event_stb[1]=1 with by=1 -> issue count_by=5, pend_1 becomes 1, and the next grant for source 1 issues count_by=1.
- Saturation: N_COUNT_BY_BITS=4, drain_en=0, source 0 strobed 20 times with by=1, then drain_en=1 -> a single increment count_by=15. With NX_EVENT_COALESCER_OVFL_EN, ovfl_sticky[0]=1 until ovfl_clr[0].
- Reset mid-drain: pend = {3,3,3,3}, drain in progress, assert rst_n low -> count_stb=0 and busy=0 immediately. After release, no increments until new events arrive.

Source files
------------

// File: rtl/nx_event_coalescer.sv
// Per-source event accumulators drained round-robin into one counter increment port.
// Optional overflow sticky flags: define NX_EVENT_COALESCER_OVFL_EN.
module nx_event_coalescer #(
    parameter int N_EVENTS        = 4,
    parameter int N_EVENT_BY_BITS = 1,
    parameter int N_COUNT_BY_BITS = 8,
    parameter int N_COUNTERS      = 16,
    parameter int ID_BASE         = 0,
    localparam int ID_BITS        = (N_COUNTERS > 1) ? $clog2(N_COUNTERS) : 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [N_EVENTS-1:0]                   event_stb,
    input  logic [N_EVENTS*N_EVENT_BY_BITS-1:0]   event_by,
    input  logic                                  drain_en,
`ifdef NX_EVENT_COALESCER_OVFL_EN
    input  logic [N_EVENTS-1:0]                   ovfl_clr,
    output logic [N_EVENTS-1:0]                   ovfl_sticky,
`endif
    output logic                                  count_stb,
    output logic [N_COUNT_BY_BITS-1:0]            count_by,
    output logic [ID_BITS-1:0]                    count_id,
    output logic                                  busy
);

    localparam int PW = (N_EVENTS > 1) ? $clog2(N_EVENTS) : 1;
    localparam int CB = N_COUNT_BY_BITS;
    localparam int EB = N_EVENT_BY_BITS;

    logic [CB-1:0]      pend_q [N_EVENTS];
    logic [CB-1:0]      pend_d [N_EVENTS];
    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic               count_stb_q, count_stb_d;
    logic [CB-1:0]      count_by_q, count_by_d;
    logic [ID_BITS-1:0] count_id_q, count_id_d;
    logic               busy_q, busy_d;
    logic               grant_valid;
    logic [PW-1:0]      grant_idx;
`ifdef NX_EVENT_COALESCER_OVFL_EN
    logic [N_EVENTS-1:0] sat;
    logic [N_EVENTS-1:0] ovfl_q, ovfl_d;
`endif

    // Rotating scan starting at rr_ptr; first nonzero accumulator wins.
    always_comb begin : grant_comb
        int unsigned idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        if (drain_en) begin
            for (int unsigned k = 0; k < N_EVENTS; k++) begin
                idx = 32'(rr_ptr_q) + k;
                if (idx >= N_EVENTS) idx = idx - N_EVENTS;
                if (!grant_valid && (pend_q[PW'(idx)] != '0)) begin
                    grant_valid = 1'b1;
                    grant_idx   = PW'(idx);
                end
            end
        end
    end

    always_comb begin : accum_comb
        logic [CB-1:0] kept;
        logic [CB:0]   add;
        logic [CB:0]   sum;
        kept   = '0;
        add    = '0;
        sum    = '0;
        busy_d = 1'b0;
`ifdef NX_EVENT_COALESCER_OVFL_EN
        sat    = '0;
`endif
        for (int unsigned i = 0; i < N_EVENTS; i++) begin
            kept = (grant_valid && (grant_idx == PW'(i))) ? '0 : pend_q[i];
            add  = '0;
            if (event_stb[i]) add[EB-1:0] = event_by[i*EB +: EB];
            sum  = {1'b0, kept} + add;
            pend_d[i] = sum[CB] ? '1 : sum[CB-1:0];
`ifdef NX_EVENT_COALESCER_OVFL_EN
            sat[i] = sum[CB];
`endif
            busy_d = busy_d | (pend_d[i] != '0);
        end
    end

    always_comb begin : out_comb
        rr_ptr_d    = rr_ptr_q;
        count_stb_d = grant_valid;
        count_by_d  = count_by_q;
        count_id_d  = count_id_q;
        if (grant_valid) begin
            rr_ptr_d   = (grant_idx == PW'(N_EVENTS - 1)) ? '0 : grant_idx + 1'b1;
            count_by_d = pend_q[grant_idx];
            count_id_d = ID_BITS'(ID_BASE) + ID_BITS'(grant_idx);
        end
    end

`ifdef NX_EVENT_COALESCER_OVFL_EN
    // A same-cycle set wins over the clear.
    always_comb begin
        ovfl_d = (ovfl_q & ~ovfl_clr) | sat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovfl_q <= '0;
        else        ovfl_q <= ovfl_d;
    end

    assign ovfl_sticky = ovfl_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_EVENTS; i++) pend_q[i] <= '0;
            rr_ptr_q    <= '0;
            count_stb_q <= 1'b0;
            count_by_q  <= '0;
            count_id_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < N_EVENTS; i++) pend_q[i] <= pend_d[i];
            rr_ptr_q    <= rr_ptr_d;
            count_stb_q <= count_stb_d;
            count_by_q  <= count_by_d;
            count_id_q  <= count_id_d;
            busy_q      <= busy_d;
        end
    end

    assign count_stb = count_stb_q;
    assign count_by  = count_by_q;
    assign count_id  = count_id_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_nx_event_coalescer.sv
// Directed bench for nx_event_coalescer: 4 sources, 1-bit increments, 4-bit accumulators, ID_BASE=8.
module tb_nx_event_coalescer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] event_stb = '0;
    logic [3:0] event_by = '0;
    logic       drain_en = 1'b0;
    logic       count_stb;
    logic [3:0] count_by;
    logic [3:0] count_id;
    logic       busy;
`ifdef NX_EVENT_COALESCER_OVFL_EN
    logic [3:0] ovfl_clr = '0;
    logic [3:0] ovfl_sticky;
`endif

    int errors = 0;
    int checks = 0;
    int edge_cnt = 0;
    int sum10 = 0;
    int sum8 = 0;
    int n8 = 0;
    int g8_edge = 0;

    nx_event_coalescer #(
        .N_EVENTS(4),
        .N_EVENT_BY_BITS(1),
        .N_COUNT_BY_BITS(4),
        .N_COUNTERS(16),
        .ID_BASE(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .event_stb(event_stb),
        .event_by(event_by),
        .drain_en(drain_en),
`ifdef NX_EVENT_COALESCER_OVFL_EN
        .ovfl_clr(ovfl_clr),
        .ovfl_sticky(ovfl_sticky),
`endif
        .count_stb(count_stb),
        .count_by(count_by),
        .count_id(count_id),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance past the edge, and log issued increments.
    task automatic step(input logic [3:0] stb, input logic [3:0] by, input logic drain);
        event_stb = stb;
        event_by  = by;
        drain_en  = drain;
        @(posedge clk);
        #1;
        edge_cnt++;
        if (count_stb) begin
            if (count_id == 4'd10) sum10 += int'(count_by);
            if (count_id == 4'd8) begin
                sum8 += int'(count_by);
                n8++;
                g8_edge = edge_cnt;
            end
        end
    endtask

    task automatic apply_reset();
        event_stb = '0;
        event_by  = '0;
        drain_en  = 1'b0;
        rst_n     = 1'b0;
        #2;
        rst_n     = 1'b1;
    endtask

    initial begin
        int pulse_edge;
        #1;
        rst_n = 1'b0;
        #2;
        check("rst_count_stb", 32'(count_stb), 0);
        check("rst_count_by", 32'(count_by), 0);
        check("rst_count_id", 32'(count_id), 0);
        check("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;

        // Single event on source 0
        step(4'b0001, 4'b0001, 1'b1);
        check("single_e1_stb", 32'(count_stb), 0);
        check("single_e1_busy", 32'(busy), 1);
        step(4'b0000, 4'b0000, 1'b1);
        check("single_e2_stb", 32'(count_stb), 1);
        check("single_e2_by", 32'(count_by), 1);
        check("single_e2_id", 32'(count_id), 8);
        check("single_e2_busy", 32'(busy), 0);
        step(4'b0000, 4'b0000, 1'b1);
        check("single_e3_stb", 32'(count_stb), 0);
        check("single_e3_by_hold", 32'(count_by), 1);

        // All sources at once
        apply_reset();
        step(4'b1111, 4'b1111, 1'b1);
        check("all_e1_stb", 32'(count_stb), 0);
        for (int k = 0; k < 4; k++) begin
            step(4'b0000, 4'b0000, 1'b1);
            check("all_stb", 32'(count_stb), 1);
            check("all_id", 32'(count_id), 32'(8 + k));
            check("all_by", 32'(count_by), 1);
            check("all_busy", 32'(busy), (k < 3) ? 1 : 0);
        end
        step(4'b0000, 4'b0000, 1'b1);
        check("all_idle_stb", 32'(count_stb), 0);

        // Grant plus same-cycle event on source 1
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            step(4'b0010, 4'b0010, 1'b0);
            check("gse_hold_stb", 32'(count_stb), 0);
        end
        step(4'b0010, 4'b0010, 1'b1);
        check("gse_first_stb", 32'(count_stb), 1);
        check("gse_first_by", 32'(count_by), 5);
        check("gse_first_id", 32'(count_id), 9);
        check("gse_first_busy", 32'(busy), 1);
        step(4'b0000, 4'b0000, 1'b1);
        check("gse_second_stb", 32'(count_stb), 1);
        check("gse_second_by", 32'(count_by), 1);
        check("gse_second_id", 32'(count_id), 9);
        check("gse_second_busy", 32'(busy), 0);
        step(4'b0000, 4'b0000, 1'b1);
        check("gse_idle_stb", 32'(count_stb), 0);

        // Saturation with drain disabled
        apply_reset();
        for (int k = 0; k < 20; k++) step(4'b0001, 4'b0001, 1'b0);
        check("sat_hold_stb", 32'(count_stb), 0);
        check("sat_hold_busy", 32'(busy), 1);
`ifdef NX_EVENT_COALESCER_OVFL_EN
        check("sat_ovfl_set", 32'(ovfl_sticky), 1);
`endif
        step(4'b0000, 4'b0000, 1'b1);
        check("sat_stb", 32'(count_stb), 1);
        check("sat_by", 32'(count_by), 15);
        check("sat_id", 32'(count_id), 8);
        step(4'b0000, 4'b0000, 1'b1);
        check("sat_after_stb", 32'(count_stb), 0);
        check("sat_after_busy", 32'(busy), 0);
`ifdef NX_EVENT_COALESCER_OVFL_EN
        check("sat_ovfl_kept", 32'(ovfl_sticky), 1);
        ovfl_clr = 4'b0001;
        step(4'b0000, 4'b0000, 1'b1);
        ovfl_clr = 4'b0000;
        check("sat_ovfl_clr", 32'(ovfl_sticky), 0);
`endif

        // Continuous source 2 with a single pulse on source 0
        apply_reset();
        sum10 = 0;
        sum8 = 0;
        n8 = 0;
        pulse_edge = 0;
        for (int k = 0; k < 12; k++) begin
            if (k == 2) begin
                step(4'b0101, 4'b0101, 1'b1);
                pulse_edge = edge_cnt;
            end else begin
                step(4'b0100, 4'b0100, 1'b1);
            end
        end
        for (int k = 0; k < 6; k++) step(4'b0000, 4'b0000, 1'b1);
        check("cont_sum_id10", 32'(sum10), 12);
        check("cont_src0_grants", 32'(n8), 1);
        check("cont_src0_sum", 32'(sum8), 1);
        check("cont_src0_latency_ok", 32'((n8 == 1) && (g8_edge - pulse_edge <= 5)), 1);
        check("cont_idle_busy", 32'(busy), 0);

        // Reset in the middle of a drain
        apply_reset();
        for (int k = 0; k < 3; k++) step(4'b1111, 4'b1111, 1'b0);
        step(4'b0000, 4'b0000, 1'b1);
        check("mid_first_stb", 32'(count_stb), 1);
        check("mid_first_by", 32'(count_by), 3);
        step(4'b0000, 4'b0000, 1'b1);
        check("mid_second_id", 32'(count_id), 9);
        rst_n = 1'b0;
        #1;
        check("mid_rst_stb", 32'(count_stb), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_by", 32'(count_by), 0);
        check("mid_rst_id", 32'(count_id), 0);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step(4'b0000, 4'b0000, 1'b1);
            check("post_rst_stb", 32'(count_stb), 0);
        end
        check("post_rst_busy", 32'(busy), 0);
        step(4'b1000, 4'b1000, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);
        check("post_rst_new_stb", 32'(count_stb), 1);
        check("post_rst_new_id", 32'(count_id), 11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
